// File: rtl/mux64_read_arbiter.sv
// Round-robin read arbiter sharing one 64:1 x 4-bit nibble mux between NREQ requesters.
// Optional background scan of the table via `define MUXARB_SCAN_EN.
module mux64_read_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 6,
  parameter int DW   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*IW-1:0] req_idx,
  output logic [NREQ-1:0]    req_ready,
  output logic [IW-1:0]      mux_s,
  input  logic [DW-1:0]      mux_y,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               busy
`ifdef MUXARB_SCAN_EN
  ,
  output logic [IW-1:0]      scan_idx,
  output logic [DW-1:0]      scan_data
`endif
);

  localparam int          PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned N  = NREQ;

  typedef enum logic {IDLE, SAMPLE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   mux_s_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   owner_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [DW-1:0]   rsp_data_q;

  logic            any_req;
  logic            grant;
  logic [PW-1:0]   winner;
  logic [IW-1:0]   win_idx;
  logic [PW-1:0]   rr_next;
  logic [NREQ-1:0] owner_oh;

  assign any_req = |req_valid;
  assign grant   = (state_q == IDLE) && any_req;

  // First set bit at or above rr_ptr, wrapping past NREQ-1 back to 0.
  always_comb begin
    logic        found;
    int unsigned j;
    found   = 1'b0;
    winner  = '0;
    win_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(rr_ptr_q) + k;
      if (j >= N) j = j - N;
      if (!found && req_valid[j]) begin
        found   = 1'b1;
        winner  = PW'(j);
        win_idx = req_idx[j*IW +: IW];
      end
    end
  end

  assign rr_next = (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = SAMPLE;
      SAMPLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready         = '0;
          req_ready[winner] = 1'b1;
        end
      end
      SAMPLE:  busy = 1'b1;
      default: ;
    endcase
  end

`ifdef MUXARB_SCAN_EN
  logic [IW-1:0] scan_cnt_q;
  logic          scan_pend_q;
  logic [IW-1:0] scan_idx_q;
  logic [DW-1:0] scan_data_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mux_s_q     <= '0;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
`ifdef MUXARB_SCAN_EN
      scan_cnt_q  <= '0;
      scan_pend_q <= 1'b0;
      scan_idx_q  <= '0;
      scan_data_q <= '0;
`endif
    end else begin
      rsp_valid_q <= '0;
      if (grant) begin
        mux_s_q  <= win_idx;
        owner_q  <= winner;
        rr_ptr_q <= rr_next;
      end
      if (state_q == SAMPLE) begin
        rsp_data_q  <= mux_y;
        rsp_valid_q <= owner_oh;
      end
`ifdef MUXARB_SCAN_EN
      // Scan slots only fill idle cycles; the capture lands one edge after the select.
      scan_pend_q <= (state_q == IDLE) && !any_req;
      if ((state_q == IDLE) && !any_req) begin
        mux_s_q    <= scan_cnt_q;
        scan_cnt_q <= scan_cnt_q + IW'(1);
      end
      if (scan_pend_q) begin
        scan_idx_q  <= mux_s_q;
        scan_data_q <= mux_y;
      end
`endif
    end
  end

  assign mux_s     = mux_s_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
`ifdef MUXARB_SCAN_EN
  assign scan_idx  = scan_idx_q;
  assign scan_data = scan_data_q;
`endif

endmodule

// File: tb/tb_mux64_read_arbiter.sv
// Self-checking bench for mux64_read_arbiter: cycle vector table plus reset/scan sequences.
// The nibble table model is tbl[i] = (5*i + 1) mod 16.
module tb_mux64_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [23:0] req_idx;
  logic [3:0]  req_ready;
  logic [5:0]  mux_s;
  logic [3:0]  mux_y;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_data;
  logic        busy;
`ifdef MUXARB_SCAN_EN
  logic [5:0]  scan_idx;
  logic [3:0]  scan_data;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] tbl [64];

  always #5 clk = ~clk;

  assign mux_y = tbl[mux_s];

  mux64_read_arbiter #(.NREQ(4), .IW(6), .DW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_idx   (req_idx),
    .req_ready (req_ready),
    .mux_s     (mux_s),
    .mux_y     (mux_y),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
`ifdef MUXARB_SCAN_EN
    ,
    .scan_idx  (scan_idx),
    .scan_data (scan_data)
`endif
  );

  typedef struct {
    logic [3:0]  rv;
    logic [23:0] idx;
    logic [3:0]  rdy;
    logic        bsy;
    logic [5:0]  ms;
    logic [3:0]  rsv;
    logic [3:0]  rsd;
  } vec_t;

  vec_t vecs [25];

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  localparam logic [23:0] IA = {6'd63, 6'd20, 6'd10, 6'd5};
  localparam logic [23:0] IB = {6'd0, 6'd37, 6'd0, 6'd0};
  localparam logic [23:0] IC = {6'd40, 6'd0, 6'd0, 6'd12};
  localparam logic [23:0] ID = {6'd0, 6'd0, 6'd63, 6'd0};

  initial begin
    for (int i = 0; i < 64; i++) tbl[i] = 4'((5 * i + 1) % 16);

    // rv, idx, ready, busy, mux_s, rsp_valid, rsp_data (values seen in that cycle)
    vecs[0]  = '{4'b0000, 24'd0, 4'b0000, 1'b0, 6'd0,  4'b0000, 4'h0};
    vecs[1]  = '{4'b1111, IA,    4'b0001, 1'b0, 6'd0,  4'b0000, 4'h0};
    vecs[2]  = '{4'b1111, IA,    4'b0000, 1'b1, 6'd5,  4'b0000, 4'h0};
    vecs[3]  = '{4'b1111, IA,    4'b0010, 1'b0, 6'd5,  4'b0001, 4'hA};
    vecs[4]  = '{4'b1111, IA,    4'b0000, 1'b1, 6'd10, 4'b0000, 4'hA};
    vecs[5]  = '{4'b1111, IA,    4'b0100, 1'b0, 6'd10, 4'b0010, 4'h3};
    vecs[6]  = '{4'b1111, IA,    4'b0000, 1'b1, 6'd20, 4'b0000, 4'h3};
    vecs[7]  = '{4'b1111, IA,    4'b1000, 1'b0, 6'd20, 4'b0100, 4'h5};
    vecs[8]  = '{4'b1111, IA,    4'b0000, 1'b1, 6'd63, 4'b0000, 4'h5};
    vecs[9]  = '{4'b1111, IA,    4'b0001, 1'b0, 6'd63, 4'b1000, 4'hC};
    vecs[10] = '{4'b0000, IA,    4'b0000, 1'b1, 6'd5,  4'b0000, 4'hC};
    vecs[11] = '{4'b0000, IA,    4'b0000, 1'b0, 6'd5,  4'b0001, 4'hA};
    vecs[12] = '{4'b0100, IB,    4'b0100, 1'b0, 6'd5,  4'b0000, 4'hA};
    vecs[13] = '{4'b0000, IB,    4'b0000, 1'b1, 6'd37, 4'b0000, 4'hA};
    vecs[14] = '{4'b0000, IB,    4'b0000, 1'b0, 6'd37, 4'b0100, 4'hA};
    vecs[15] = '{4'b1001, IC,    4'b1000, 1'b0, 6'd37, 4'b0000, 4'hA};
    vecs[16] = '{4'b0001, IC,    4'b0000, 1'b1, 6'd40, 4'b0000, 4'hA};
    vecs[17] = '{4'b0001, IC,    4'b0001, 1'b0, 6'd40, 4'b1000, 4'h9};
    vecs[18] = '{4'b0000, IC,    4'b0000, 1'b1, 6'd12, 4'b0000, 4'h9};
    vecs[19] = '{4'b0010, ID,    4'b0010, 1'b0, 6'd12, 4'b0001, 4'hD};
    vecs[20] = '{4'b0010, 24'd0, 4'b0000, 1'b1, 6'd63, 4'b0000, 4'hD};
    vecs[21] = '{4'b0010, 24'd0, 4'b0010, 1'b0, 6'd63, 4'b0010, 4'hC};
    vecs[22] = '{4'b0000, 24'd0, 4'b0000, 1'b1, 6'd0,  4'b0000, 4'hC};
    vecs[23] = '{4'b0000, 24'd0, 4'b0000, 1'b0, 6'd0,  4'b0010, 4'h1};
    vecs[24] = '{4'b0000, 24'd0, 4'b0000, 1'b0, 6'd0,  4'b0000, 4'h1};

    reset     = 1'b1;
    req_valid = '0;
    req_idx   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int r = 0; r < 25; r++) begin
      @(negedge clk);
      req_valid = vecs[r].rv;
      req_idx   = vecs[r].idx;
      #1;
      chk("req_ready", r, 32'(req_ready), 32'(vecs[r].rdy));
      chk("busy",      r, 32'(busy),      32'(vecs[r].bsy));
`ifndef MUXARB_SCAN_EN
      chk("mux_s",     r, 32'(mux_s),     32'(vecs[r].ms));
`endif
      chk("rsp_valid", r, 32'(rsp_valid), 32'(vecs[r].rsv));
      chk("rsp_data",  r, 32'(rsp_data),  32'(vecs[r].rsd));
    end

    // Reset in the middle of SAMPLE: pending access dropped, rr_ptr back to 0.
    @(negedge clk);
    req_valid = 4'b0010;
    req_idx   = {6'd0, 6'd0, 6'd50, 6'd0};
    #1;
    chk("rst_pre_ready", 100, 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("rst_pre_busy", 101, 32'(busy), 32'h1);
    chk("rst_pre_mux_s", 101, 32'(mux_s), 32'd50);
    reset = 1'b1;
    #1;
    chk("rst_busy", 102, 32'(busy), 32'h0);
    chk("rst_mux_s", 102, 32'(mux_s), 32'h0);
    chk("rst_rsp_valid", 102, 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 102, 32'(rsp_data), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("post_rst_rsp_valid", 103 + c, 32'(rsp_valid), 32'h0);
    end
    req_valid = 4'b1010;
    req_idx   = {6'd7, 6'd0, 6'd33, 6'd0};
    #1;
    chk("post_rst_rr_grant", 106, 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 4'b1000;
    @(negedge clk);
    #1;
    chk("post_rst_rsp_valid", 107, 32'(rsp_valid), 32'h2);
    chk("post_rst_rsp_data", 107, 32'(rsp_data), 32'(tbl[33]));
    chk("post_rst_next_grant", 107, 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = '0;

`ifdef MUXARB_SCAN_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      #1;
      if (k >= 2) begin
        chk("scan_idx",  200 + k, 32'(scan_idx),  32'((k - 2) % 64));
        chk("scan_data", 200 + k, 32'(scan_data), 32'(tbl[(k - 2) % 64]));
      end
    end
    req_valid = 4'b0001;
    req_idx   = {6'd0, 6'd0, 6'd0, 6'd45};
    #1;
    chk("scan_preempt_ready", 400, 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("scan_preempt_mux_s", 401, 32'(mux_s), 32'd45);
    chk("scan_idx_at_grant", 401, 32'(scan_idx), 32'd21);
    @(negedge clk);
    #1;
    chk("scan_rsp_valid", 402, 32'(rsp_valid), 32'h1);
    chk("scan_rsp_data", 402, 32'(rsp_data), 32'(tbl[45]));
    repeat (2) @(negedge clk);
    #1;
    chk("scan_resume_idx", 403, 32'(scan_idx), 32'd22);
    chk("scan_resume_data", 403, 32'(scan_data), 32'(tbl[22]));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
